// File: rtl/clap_bpu_pkg.sv
// -----------------------------------------------------------------------------
// clap_bpu_pkg
// Shared types for the branch-predictor update path.
//   BPU_ADDR_WIDTH : width of PC/target fields carried in an update record.
//                    The arbiter's ADDR_WIDTH must not exceed this value.
//   bpu_state_e    : arbiter FSM states (INIT walk / RUN).
//   bpu_upd_t      : one buffered branch-resolution update {pc, tgt, taken}.
// -----------------------------------------------------------------------------
package clap_bpu_pkg;

  localparam int unsigned BPU_ADDR_WIDTH = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpu_state_e;

  typedef struct packed {
    logic [BPU_ADDR_WIDTH-1:0] pc;
    logic [BPU_ADDR_WIDTH-1:0] tgt;
    logic                      taken;
  } bpu_upd_t;

endpackage

// File: rtl/bpu_upd_fifo.sv
// -----------------------------------------------------------------------------
// bpu_upd_fifo
// Two-push / one-pop FIFO of update records. push0 is the older request; when
// both pushes are active push0 lands ahead of push1. A lone push1 is also
// accepted and takes the next free slot.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : empty the FIFO on the next edge (contents dropped)
//   push0/push0_rec     : older enqueue request and record
//   push1/push1_rec     : younger enqueue request and record
//   pop                 : dequeue the head this cycle
//   head                : record at the read pointer (valid when !empty)
//   empty               : no entries
//   free_ge2            : at least two free entries
// Parameter FIFO_DEPTH: power of two, >= 2.
// -----------------------------------------------------------------------------
module bpu_upd_fifo
  import clap_bpu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push0,
  input  bpu_upd_t push0_rec,
  input  logic     push1,
  input  bpu_upd_t push1_rec,
  input  logic     pop,
  output bpu_upd_t head,
  output logic     empty,
  output logic     free_ge2
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  // One extra pointer bit: equal pointers mean empty, pointers differing only
  // in the MSB mean full, and the subtraction below yields the occupancy.
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] used;
  logic [IDX_W-1:0] widx0, widx1;
  logic [1:0]       n_push;
  bpu_upd_t         first_rec;
  bpu_upd_t         mem_q [FIFO_DEPTH];

  assign n_push    = {1'b0, push0} + {1'b0, push1};
  assign first_rec = push0 ? push0_rec : push1_rec;
  assign widx0     = wptr_q[IDX_W-1:0];
  assign widx1     = widx0 + 1'b1;

  assign used      = wptr_q - rptr_q;
  assign empty     = (wptr_q == rptr_q);
  assign free_ge2  = (used <= PTR_W'(FIFO_DEPTH - 2));
  assign head      = mem_q[rptr_q[IDX_W-1:0]];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    wptr_d = wptr_q + PTR_W'(n_push);
    rptr_d = rptr_q + PTR_W'(pop);
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the data would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push0 || push1) mem_q[widx0] <= first_rec;
    if (push0 && push1) mem_q[widx1] <= push1_rec;
  end

endmodule

// File: rtl/bpu_update_arb.sv
// -----------------------------------------------------------------------------
// bpu_update_arb
// Arbitrates branch-resolution updates from two pipes onto the predictor
// table's single write port. After reset or clr the whole table is walked and
// zeroed (INIT); afterwards (RUN) updates are buffered and drained one per
// cycle whenever the predictor itself is not using the port (pred_we=0).
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   clr                       : restart the INIT walk, drop buffered updates
//   upd{0,1}_vld/pc/tgt/taken : update requests, pipe0 is older
//   upd_rdy                   : both update slots may be presented
//   pred_we                   : predictor owns the write port this cycle
//   tbl_we/waddr/wslot/wtgt/wtaken : table write port
//   busy                      : INIT walk in progress
// Build option CLAP_BPU_UPD_BYPASS_EN: with the FIFO empty and the port free,
// an update is written in its arrival cycle instead of being buffered.
// ADDR_WIDTH must not exceed clap_bpu_pkg::BPU_ADDR_WIDTH.
// -----------------------------------------------------------------------------
module bpu_update_arb
  import clap_bpu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned HASH_DEPTH = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  upd0_vld,
  input  logic [ADDR_WIDTH-1:0] upd0_pc,
  input  logic [ADDR_WIDTH-1:0] upd0_tgt,
  input  logic                  upd0_taken,
  input  logic                  upd1_vld,
  input  logic [ADDR_WIDTH-1:0] upd1_pc,
  input  logic [ADDR_WIDTH-1:0] upd1_tgt,
  input  logic                  upd1_taken,
  output logic                  upd_rdy,
  input  logic                  pred_we,
  output logic                  tbl_we,
  output logic [HASH_DEPTH-1:0] tbl_waddr,
  output logic                  tbl_wslot,
  output logic [ADDR_WIDTH-1:0] tbl_wtgt,
  output logic                  tbl_wtaken,
  output logic                  busy
);

  localparam logic [HASH_DEPTH-1:0] IDX_LAST = '1;

  bpu_state_e            state_q, state_d;
  logic [HASH_DEPTH-1:0] idx_q, idx_d;

  bpu_upd_t rec0, rec1, head, wr_rec;
  logic     fifo_empty, fifo_free_ge2;
  logic     push0, push1, pop;
  logic     acc0, acc1;
  logic     unused_wr_pc;

  assign rec0 = '{pc: BPU_ADDR_WIDTH'(upd0_pc), tgt: BPU_ADDR_WIDTH'(upd0_tgt), taken: upd0_taken};
  assign rec1 = '{pc: BPU_ADDR_WIDTH'(upd1_pc), tgt: BPU_ADDR_WIDTH'(upd1_tgt), taken: upd1_taken};

  assign busy    = (state_q == ST_INIT);
  assign upd_rdy = (state_q == ST_RUN) && fifo_free_ge2;
  assign acc0    = upd0_vld && upd_rdy;
  assign acc1    = upd1_vld && upd_rdy;

  // Only pc[HASH_DEPTH+2:2] reaches the table; the rest of the PC is carried
  // through the record unchanged.
  assign unused_wr_pc = ^wr_rec.pc;

  bpu_upd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clr),
    .push0     (push0),
    .push0_rec (rec0),
    .push1     (push1),
    .push1_rec (rec1),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .free_ge2  (fifo_free_ge2)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: the walk index wraps to 0 as the last entry is written, so
  // RUN always starts with idx at 0 and a later clr restarts cleanly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clr) begin
      state_d = ST_INIT;
      idx_d   = '0;
    end else if (state_q == ST_INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX_LAST) state_d = ST_RUN;
    end
  end

  // Outputs and FIFO control.
  always_comb begin
    push0      = 1'b0;
    push1      = 1'b0;
    pop        = 1'b0;
    tbl_we     = 1'b0;
    wr_rec     = '0;
    tbl_waddr  = '0;
    tbl_wslot  = 1'b0;
    tbl_wtgt   = '0;
    tbl_wtaken = 1'b0;

    if (state_q == ST_INIT) begin
      tbl_we    = 1'b1;
      tbl_waddr = idx_q;
    end else begin
`ifdef CLAP_BPU_UPD_BYPASS_EN
      if (fifo_empty && !pred_we && !clr && (acc0 || acc1)) begin
        tbl_we = 1'b1;
        wr_rec = acc0 ? rec0 : rec1;
        push1  = acc0 && acc1;
      end else begin
        push0 = acc0;
        push1 = acc1;
      end
`else
      push0 = acc0;
      push1 = acc1;
`endif
      // A pending clr wins over the drain so flushed entries are never written.
      if (!fifo_empty && !pred_we && !clr) begin
        pop    = 1'b1;
        tbl_we = 1'b1;
        wr_rec = head;
      end
      // Fields are forced to zero when idle, keeping unwritten storage off the port.
      tbl_waddr  = wr_rec.pc[HASH_DEPTH+2:3];
      tbl_wslot  = wr_rec.pc[2];
      tbl_wtgt   = ADDR_WIDTH'(wr_rec.tgt);
      tbl_wtaken = wr_rec.taken;
    end

    if (rst) tbl_we = 1'b0;
  end

endmodule
